// File: rtl/jzjpcc_dual_port_sram.sv
// True dual-port inferred SRAM with per-lane write enables, read-first collisions and a post-reset clear sweep.
// Optional macro JZJPCC_SRAM_OUTPUT_REG_EN adds a second read-data register stage (latency 2).
module jzjpcc_dual_port_sram #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    output logic                                 ready,
    input  logic [ADDR_WIDTH-1:0]                addressA,
    input  logic [DATA_WIDTH-1:0]                writeA,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     byteEnableA,
    input  logic                                 writeEnableA,
    input  logic                                 readEnableA,
    output logic [DATA_WIDTH-1:0]                readA,
    input  logic [ADDR_WIDTH-1:0]                addressB,
    input  logic [DATA_WIDTH-1:0]                writeB,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     byteEnableB,
    input  logic                                 writeEnableB,
    input  logic                                 readEnableB,
    output logic [DATA_WIDTH-1:0]                readB
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_count_q, clear_count_d;
    logic                    ready_q, ready_d;

    // Effective write request per port; port A also carries the clear sweep.
    logic                    wa_en_c;
    logic [ADDR_WIDTH-1:0]   wa_addr_c;
    logic [DATA_WIDTH-1:0]   wa_data_c;
    logic [NB-1:0]           wa_be_c;
    logic                    wb_en_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_a_q, rd_b_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_CLEAR;
            clear_count_q <= '0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            clear_count_q <= clear_count_d;
            ready_q       <= ready_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clear_count_d = clear_count_q;
        ready_d       = ready_q;
        wa_en_c       = 1'b0;
        wa_addr_c     = addressA;
        wa_data_c     = writeA;
        wa_be_c       = byteEnableA;
        wb_en_c       = 1'b0;
        case (state_q)
            S_CLEAR: begin
                ready_d = 1'b0;
                if (CLEAR_ON_RESET != 0) begin
                    wa_en_c       = 1'b1;
                    wa_addr_c     = clear_count_q;
                    wa_data_c     = '0;
                    wa_be_c       = '1;
                    clear_count_d = clear_count_q + ADDR_WIDTH'(1);
                    if (clear_count_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = S_READY;
                        ready_d = 1'b1;
                    end
                end else begin
                    state_d = S_READY;
                    ready_d = 1'b1;
                end
            end
            S_READY: begin
                ready_d = 1'b1;
                wa_en_c = writeEnableA;
                wb_en_c = writeEnableB;
            end
            default: begin
                state_d = S_CLEAR;
                ready_d = 1'b0;
            end
        endcase
    end

    // Port A lanes are written after port B so A wins overlapping lanes.
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(NB); i++) begin
            if (wb_en_c && byteEnableB[i]) begin
                mem[addressB][i*BYTE_WIDTH +: BYTE_WIDTH] <= writeB[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wa_en_c && wa_be_c[i]) begin
                mem[wa_addr_c][i*BYTE_WIDTH +: BYTE_WIDTH] <= wa_data_c[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read-first: the array value sampled here predates any write on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            if (ready_q && readEnableA) begin
                rd_a_q <= mem[addressA];
            end
            if (ready_q && readEnableB) begin
                rd_b_q <= mem[addressB];
            end
        end
    end

`ifdef JZJPCC_SRAM_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] out_a_q, out_b_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_a_q <= '0;
            out_b_q <= '0;
        end else if (ready_q) begin
            out_a_q <= rd_a_q;
            out_b_q <= rd_b_q;
        end else begin
            out_a_q <= '0;
            out_b_q <= '0;
        end
    end

    assign readA = out_a_q;
    assign readB = out_b_q;
`else
    assign readA = rd_a_q;
    assign readB = rd_b_q;
`endif

    assign ready = ready_q;

endmodule

// File: doc/jzjpcc_dual_port_sram.md
Name: jzjpcc_dual_port_sram

Overview:
Parametrised true dual-port inferred SRAM. Supersedes the fixed 16-bit inferred SRAM. Adds configurable width and depth, per-byte write enables, defined cross-port collision rules and a post-reset clear sequencer. Serves as backing store for instruction and data memory in the pipelined core; the fetch unit uses port A and the memory stage uses port B.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per byte lane; lane count NB = DATA_WIDTH/BYTE_WIDTH
ADDR_WIDTH, 10, word address bits; DEPTH = 2**ADDR_WIDTH (localparam)
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip clearing

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
ready  out  1  high when the array accepts requests
addressA  in  ADDR_WIDTH  port A word address
writeA  in  DATA_WIDTH  port A write data
byteEnableA  in  NB  port A per-lane write mask
writeEnableA  in  1  port A write strobe
readEnableA  in  1  port A read strobe
readA  out  DATA_WIDTH  port A registered read data
addressB  in  ADDR_WIDTH  port B word address
writeB  in  DATA_WIDTH  port B write data
byteEnableB  in  NB  port B per-lane write mask
writeEnableB  in  1  port B write strobe
readEnableB  in  1  port B read strobe
readB  out  DATA_WIDTH  port B registered read data

Behaviour:
- Reset (async assert, sync release): ready=0, readA=0, readB=0, state=CLEAR, clearCount=0. Array contents are not reset directly.
- FSM states: CLEAR, READY.
- CLEAR, CLEAR_ON_RESET=1: each cycle writes all-zero to address clearCount through the port A write path, then clearCount++. After the write at DEPTH-1, state goes to READY and ready=1 on the next edge. ready therefore rises DEPTH cycles after the first edge following reset release.
- CLEAR, CLEAR_ON_RESET=0: state goes to READY on the first edge after release. ready=1 from then on.
- While ready=0: all port strobes are ignored, no user writes occur, readA/readB hold 0.
- Reset asserted mid-clear or mid-operation: returns to CLEAR, clearCount=0, outputs zeroed. The clear restarts from address 0.
- Write, per port: on an edge with writeEnableX=1 and ready=1, lane i of mem[addressX] takes writeX lane i where byteEnableX[i]=1. Other lanes are unchanged. writeEnable with byteEnable=0 is a no-op.
- Read: on an edge with readEnableX=1 and ready=1, readX <= mem[addressX]. Latency is 1 cycle. readX holds its value when readEnableX=0.
- Same-port read+write, same address: read-first; readX returns pre-write data.
- Cross-port read vs write, same address: reader gets pre-write data (read-first). The new data is visible on the following access.
- Cross-port write vs write, same address: for lanes enabled on both ports, port A wins. Lanes enabled on only one port take that port's data.
- Address range: full 2**ADDR_WIDTH; no out-of-range condition exists.

Optional Feature:
Macro JZJPCC_SRAM_OUTPUT_REG_EN.
- Defined: a second register stage sits on readA/readB. Read latency is 2 cycles; the stage is cleared by reset and held at 0 while ready=0. The stage captures every cycle once ready=1, so it follows the first stage one cycle later.
- Undefined: single register stage, latency 1 as described above.

Test Plan:
- Reset then wait with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> ready=0 for 16 cycles, ready=1 at cycle 16. Subsequent reads of addresses 0..15 all return 0x00000000.
- Write 0xDEADBEEF to A addr 3 with byteEnableA=4'b1111, then write 0x000000AA to B addr 3 with byteEnableB=4'b0001, then read addr 3 on A -> 0xDEADBEAA one cycle after the read strobe (two cycles with JZJPCC_SRAM_OUTPUT_REG_EN).
- Same edge: A writes 0x11111111 mask 4'b0011 and B writes 0x22222222 mask 4'b0110, both to addr 5 -> later read returns 0x00221111.
- Addr 7 holds 0x12345678. Same edge: B reads addr 7 while A writes 0xCAFEF00D to addr 7 -> readB=0x12345678. Next read of addr 7 returns 0xCAFEF00D.
- Assert reset for 1 cycle halfway through the clear sweep -> ready drops to 0, readA=readB=0, and ready rises DEPTH cycles after release.
- CLEAR_ON_RESET=0 -> ready=1 one edge after reset release. A write/read of 0xA5A5A5A5 at addr 0 round-trips.
